// File: rtl/axi_sram_slave.sv
// AXI3-style single-port SRAM slave: independent read and write burst engines sharing one
// word-addressed memory with byte-lane write strobes and combinational read data.
module axi_sram_slave #(
   parameter int unsigned MEM_AW = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   // AW channel
   input  logic [3:0]  awid_i,
   input  logic [31:0] awaddr_i,
   input  logic [3:0]  awlen_i,
   input  logic [2:0]  awsize_i,
   input  logic [1:0]  awburst_i,
   input  logic        awvalid_i,
   output logic        awready_o,
   // W channel
   input  logic [3:0]  wid_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   input  logic        wlast_i,
   input  logic        wvalid_i,
   output logic        wready_o,
   // B channel
   output logic [3:0]  bid_o,
   output logic [1:0]  bresp_o,
   output logic        bvalid_o,
   input  logic        bready_i,
   // AR channel
   input  logic [3:0]  arid_i,
   input  logic [31:0] araddr_i,
   input  logic [3:0]  arlen_i,
   input  logic [2:0]  arsize_i,
   input  logic [1:0]  arburst_i,
   input  logic        arvalid_i,
   output logic        arready_o,
   // R channel
   output logic [3:0]  rid_o,
   output logic [31:0] rdata_o,
   output logic [1:0]  rresp_o,
   output logic        rlast_o,
   output logic        rvalid_o,
   input  logic        rready_i
);

   typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;
   typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

   logic [31:0] mem [0:(1 << MEM_AW) - 1];

   // Read engine state
   rd_state_e         rd_state_q;
   logic [MEM_AW-1:0] rd_idx_q;
   logic [3:0]        rd_len_q;
   logic [3:0]        rd_beat_q;
   logic              rd_fixed_q;
   logic              arready_q, rvalid_q, rlast_q;
   logic [3:0]        rid_q;
   logic [1:0]        rresp_q;

   // Write engine state
   wr_state_e         wr_state_q;
   logic [MEM_AW-1:0] wr_idx_q;
   logic [3:0]        wr_len_q;
   logic [3:0]        wr_beat_q;
   logic              wr_fixed_q;
   logic              wr_err_q;
   logic              awready_q, wready_q, bvalid_q;
   logic [3:0]        bid_q;
   logic [1:0]        bresp_q;
   logic              wr_err_next;

   // Address bits outside the word index and the W-channel id carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{wid_i, araddr_i[31:MEM_AW+2], araddr_i[1:0],
                          awaddr_i[31:MEM_AW+2], awaddr_i[1:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_state_q <= RD_IDLE;
         rd_idx_q   <= '0;
         rd_len_q   <= '0;
         rd_beat_q  <= '0;
         rd_fixed_q <= 1'b0;
         arready_q  <= 1'b1;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rid_q      <= '0;
         rresp_q    <= '0;
      end else begin
         unique case (rd_state_q)
            RD_IDLE: begin
               if (arvalid_i) begin
                  rd_idx_q   <= araddr_i[MEM_AW+1:2];
                  rd_len_q   <= arlen_i;
                  rd_beat_q  <= '0;
                  rd_fixed_q <= (arburst_i == 2'b00);
                  rid_q      <= arid_i;
                  rresp_q    <= (arsize_i != 3'b010) ? 2'b10 : 2'b00;
                  rlast_q    <= (arlen_i == 4'd0);
                  arready_q  <= 1'b0;
                  rvalid_q   <= 1'b1;
                  rd_state_q <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (rready_i) begin
                  rd_beat_q <= rd_beat_q + 4'd1;
                  if (!rd_fixed_q) rd_idx_q <= rd_idx_q + 1'b1;
                  if (rlast_q) begin
                     rvalid_q   <= 1'b0;
                     rlast_q    <= 1'b0;
                     arready_q  <= 1'b1;
                     rd_state_q <= RD_IDLE;
                  end else begin
                     rlast_q <= ((rd_beat_q + 4'd1) == rd_len_q);
                  end
               end
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

   assign wr_err_next = wr_err_q | (wlast_i != (wr_beat_q == wr_len_q));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state_q <= WR_IDLE;
         wr_idx_q   <= '0;
         wr_len_q   <= '0;
         wr_beat_q  <= '0;
         wr_fixed_q <= 1'b0;
         wr_err_q   <= 1'b0;
         awready_q  <= 1'b1;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bid_q      <= '0;
         bresp_q    <= '0;
      end else begin
         unique case (wr_state_q)
            WR_IDLE: begin
               if (awvalid_i) begin
                  wr_idx_q   <= awaddr_i[MEM_AW+1:2];
                  wr_len_q   <= awlen_i;
                  wr_beat_q  <= '0;
                  wr_fixed_q <= (awburst_i == 2'b00);
                  // Size error is known up front; later wlast mismatches OR into it.
                  wr_err_q   <= (awsize_i != 3'b010);
                  bid_q      <= awid_i;
                  awready_q  <= 1'b0;
                  wready_q   <= 1'b1;
                  wr_state_q <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (wvalid_i) begin
                  wr_err_q  <= wr_err_next;
                  wr_beat_q <= wr_beat_q + 4'd1;
                  if (!wr_fixed_q) wr_idx_q <= wr_idx_q + 1'b1;
                  if (wr_beat_q == wr_len_q) begin
                     wready_q   <= 1'b0;
                     bvalid_q   <= 1'b1;
                     bresp_q    <= wr_err_next ? 2'b10 : 2'b00;
                     wr_state_q <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (bready_i) begin
                  bvalid_q   <= 1'b0;
                  awready_q  <= 1'b1;
                  wr_state_q <= WR_IDLE;
               end
            end
            default: wr_state_q <= WR_IDLE;
         endcase
      end
   end

   // Memory is deliberately not reset; writes land at the edge so a same-cycle read sees old data.
   always_ff @(posedge clk) begin
      if (rst_n && wready_q && wvalid_i) begin
         for (int k = 0; k < 4; k++) begin
            if (wstrb_i[k]) mem[wr_idx_q][8*k +: 8] <= wdata_i[8*k +: 8];
         end
      end
   end

   assign arready_o = arready_q;
   assign rvalid_o  = rvalid_q;
   assign rlast_o   = rlast_q;
   assign rid_o     = rid_q;
   assign rresp_o   = rresp_q;
   assign rdata_o   = mem[rd_idx_q];
   assign awready_o = awready_q;
   assign wready_o  = wready_q;
   assign bvalid_o  = bvalid_q;
   assign bid_o     = bid_q;
   assign bresp_o   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: burst writes/reads, strobes, error responses, FIXED bursts,
// address aliasing and reset during a read burst.
module tb_axi_sram_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  awid, awlen, wid, wstrb, bid, arid, arlen, rid;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   axi_sram_slave #(.MEM_AW(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
      .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready),
      .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
      .wvalid_i(wvalid), .wready_o(wready),
      .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
      .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
      .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready),
      .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
      .rvalid_o(rvalid), .rready_i(rready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Each beat carries base+i; wlast is raised on beat last_beat. Beats keep being offered
   // while wready is high, so the number the slave accepts is observable.
   task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] base, input logic [3:0] strb, input int last_beat,
                           input logic [1:0] exp_resp);
      int beats = 0;
      bit done = 1'b0;
      @(negedge clk);
      check("awready_idle", {31'd0, awready}, 32'd1);
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (wready) begin
            wvalid = 1'b1;
            wdata  = base + 32'(beats);
            wstrb  = strb;
            wlast  = (beats == last_beat);
            beats++;
         end else begin
            wvalid = 1'b0;
            wlast  = 1'b0;
            done   = bvalid;
         end
      end
      check("wr_beats", 32'(beats), 32'(len) + 32'd1);
      check("bvalid", {31'd0, bvalid}, 32'd1);
      check("bid", {28'd0, bid}, {28'd0, id});
      check("bresp", {30'd0, bresp}, {30'd0, exp_resp});
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("b_done", {30'd0, bvalid, awready}, 32'b01);
   endtask

   // Expected data per beat comes from exp_q; toggle drives rready 1,0,1,0,...
   task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                           input logic [1:0] exp_resp);
      int beat = 0;
      @(negedge clk);
      check("arready_idle", {31'd0, arready}, 32'd1);
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      for (int cyc = 0; cyc < 64 && beat <= int'(len); cyc++) begin
         if (cyc > 0) @(negedge clk);
         rready = toggle ? (cyc % 2 == 0) : 1'b1;
         check("rvalid", {31'd0, rvalid}, 32'd1);
         if (rvalid) begin
            check("rdata", rdata, exp_q[beat]);
            check("rid", {28'd0, rid}, {28'd0, id});
            check("rresp", {30'd0, rresp}, {30'd0, exp_resp});
            check("rlast", {31'd0, rlast}, {31'd0, beat == int'(len)});
            check("arready_busy", {31'd0, arready}, 32'd0);
            if (rready) beat++;
         end
      end
      check("rd_beats", 32'(beat), 32'(len) + 32'd1);
      @(negedge clk);
      rready = 1'b0;
      check("r_done", {30'd0, rvalid, arready}, 32'b01);
   endtask

   initial begin
      rst_n = 1'b0;
      {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
      {wid, wdata, wstrb, wlast, wvalid, bready} = '0;
      {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", {28'd0, arready, awready, wready, rvalid}, 32'b1100);
      check("rst_b", {28'd0, bvalid, rlast, bresp}, 32'd0);
      check("rst_ids", {20'd0, rid, bid, rresp, 2'b00}, 32'd0);
      rst_n = 1'b1;

      // INCR write of four words then read back with rready stalls
      wr_burst(4'd5, 32'h100, 4'd3, 3'b010, 2'b01, 32'hA0, 4'hF, 3, 2'b00);
      check("mem_40", dut.mem[10'h40], 32'hA0);
      check("mem_43", dut.mem[10'h43], 32'hA3);
      exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      rd_burst(4'd7, 32'h100, 4'd3, 3'b010, 2'b01, 1'b1, 2'b00);

      // Byte-strobed partial write
      dut.mem[10'h40] = 32'h11223344;
      wr_burst(4'd1, 32'h100, 4'd0, 3'b010, 2'b01, 32'hAABBCCDD, 4'b0101, 0, 2'b00);
      exp_q = '{32'h11BB33DD};
      rd_burst(4'd2, 32'h100, 4'd0, 3'b010, 2'b01, 1'b0, 2'b00);

      // Early wlast still takes len+1 beats but flags SLVERR; narrow read flags SLVERR
      wr_burst(4'd9, 32'h200, 4'd1, 3'b010, 2'b01, 32'h55, 4'hF, 0, 2'b10);
      exp_q = '{32'h55, 32'h56};
      rd_burst(4'd4, 32'h200, 4'd1, 3'b001, 2'b01, 1'b0, 2'b10);

      // FIXED burst and upper-address aliasing
      dut.mem[10'h2] = 32'hCAFEF00D;
      dut.mem[10'h3] = 32'h0BADBEEF;
      exp_q = '{32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
      rd_burst(4'd6, 32'h8, 4'd2, 3'b010, 2'b00, 1'b0, 2'b00);
      exp_q = '{32'hCAFEF00D};
      rd_burst(4'd8, 32'h1008, 4'd0, 3'b010, 2'b01, 1'b0, 2'b00);

      // Reset asserted while the second beat of a read is on the bus
      @(negedge clk);
      arid = 4'd3; araddr = 32'h100; arlen = 4'd3; arsize = 3'b010; arburst = 2'b01;
      arvalid = 1'b1;
      @(negedge clk);
      arvalid = 1'b0;
      rready  = 1'b1;
      @(negedge clk);
      check("mid_rvalid", {31'd0, rvalid}, 32'd1);
      check("mid_rdata", rdata, 32'hA1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      rready = 1'b0;
      check("rst_mid", {28'd0, rvalid, arready, rlast, 1'b0}, 32'b0100);
      check("rst_mid_rid", {28'd0, rid}, 32'd0);
      exp_q = '{32'h11BB33DD, 32'hA1};
      rd_burst(4'd12, 32'h100, 4'd1, 3'b010, 2'b01, 1'b0, 2'b00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
